// File: rtl/iomem_button_ctrl.sv
// Push-button peripheral on the picosoc iomem bus: synchronises and debounces
// active-low buttons, latches press/release events and raises a level IRQ.
module iomem_button_ctrl #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned DEB_W       = 16,
  parameter int unsigned DEB_DEFAULT = 12000,
  parameter logic [7:0]  ADDR_HI     = 8'h07
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [N_BTN-1:0] btn_n,
  output logic             irq
);

  localparam int unsigned CW         = DEB_W + 1;
  localparam logic [1:0]  REG_STATUS = 2'd0;
  localparam logic [1:0]  REG_EVENTS = 2'd1;
  localparam logic [1:0]  REG_IRQEN  = 2'd2;
  localparam logic [1:0]  REG_PERIOD = 2'd3;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_stable;
  logic [DEB_W-1:0] r_cnt [N_BTN];
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;
  logic [N_BTN-1:0] r_en_press;
  logic [N_BTN-1:0] r_en_release;
  logic [DEB_W-1:0] r_period;
  logic             r_ready;
  logic [31:0]      r_rdata;
  logic             r_irq;

  logic [N_BTN-1:0] w_s;
  logic [DEB_W-1:0] w_eff_period;
  logic [CW-1:0]    w_cnt_inc [N_BTN];
  logic [N_BTN-1:0] w_fire;
  logic [N_BTN-1:0] w_press_set;
  logic [N_BTN-1:0] w_release_set;

  logic             w_hit;
  logic             w_wr;
  logic [1:0]       w_sel;
  logic [31:0]      w_events_word;
  logic [31:0]      w_en_word;
  logic [31:0]      w_rdata_c;
  logic [N_BTN-1:0] w_press_clr;
  logic [N_BTN-1:0] w_release_clr;
  logic [N_BTN-1:0] w_en_press_nxt;
  logic [N_BTN-1:0] w_en_release_nxt;
  logic [DEB_W-1:0] w_period_nxt;
  logic             w_unused;

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_irq;

  // Only addr[31:24] and addr[3:2] decode; the remaining bus bits are ignored.
  assign w_unused = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata};

  // Two-flop synchroniser; the pins idle high so the flops reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  // Debounce qualification; the extra counter bit keeps the compare overflow-free.
  always_comb begin
    w_eff_period  = (r_period == '0) ? DEB_W'(1) : r_period;
    w_fire        = '0;
    w_press_set   = '0;
    w_release_set = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      w_cnt_inc[i]     = {1'b0, r_cnt[i]} + CW'(1);
      w_fire[i]        = (w_s[i] != r_stable[i]) && (w_cnt_inc[i] >= {1'b0, w_eff_period});
      w_press_set[i]   = w_fire[i] & w_s[i];
      w_release_set[i] = w_fire[i] & ~w_s[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (w_s[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_fire[i]) begin
          r_stable[i] <= w_s[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= w_cnt_inc[i][DEB_W-1:0];
        end
      end
    end
  end

  // Bus decode: a hit is refused while the previous ack is still high.
  assign w_hit = iomem_valid && (iomem_addr[31:24] == ADDR_HI) && !r_ready;
  assign w_wr  = w_hit && (iomem_wstrb != 4'b0000);
  assign w_sel = iomem_addr[3:2];

  always_comb begin
    w_events_word              = '0;
    w_events_word[N_BTN-1:0]   = r_press;
    w_events_word[8 +: N_BTN]  = r_release;
    w_en_word                  = '0;
    w_en_word[N_BTN-1:0]       = r_en_press;
    w_en_word[8 +: N_BTN]      = r_en_release;
    w_rdata_c                  = '0;
    case (w_sel)
      REG_STATUS: w_rdata_c = 32'(r_stable);
      REG_EVENTS: w_rdata_c = w_events_word;
      REG_IRQEN:  w_rdata_c = w_en_word;
      REG_PERIOD: w_rdata_c = 32'(r_period);
      default:    w_rdata_c = '0;
    endcase
  end

  // Write-side next values; EVENTS clears and IRQ_EN/PERIOD updates are per byte lane.
  always_comb begin
    w_press_clr      = '0;
    w_release_clr    = '0;
    w_en_press_nxt   = r_en_press;
    w_en_release_nxt = r_en_release;
    w_period_nxt     = r_period;
    if (w_wr && (w_sel == REG_EVENTS)) begin
      if (iomem_wstrb[0]) w_press_clr   = iomem_wdata[N_BTN-1:0];
      if (iomem_wstrb[1]) w_release_clr = iomem_wdata[8 +: N_BTN];
    end
    if (w_wr && (w_sel == REG_IRQEN)) begin
      if (iomem_wstrb[0]) w_en_press_nxt   = iomem_wdata[N_BTN-1:0];
      if (iomem_wstrb[1]) w_en_release_nxt = iomem_wdata[8 +: N_BTN];
    end
    if (w_wr && (w_sel == REG_PERIOD)) begin
      for (int b = 0; b < int'(DEB_W); b++) begin
        if (iomem_wstrb[b / 8]) w_period_nxt[b] = iomem_wdata[b];
      end
    end
  end

  // Register file and bus response; a fresh event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready      <= 1'b0;
      r_rdata      <= '0;
      r_press      <= '0;
      r_release    <= '0;
      r_en_press   <= '0;
      r_en_release <= '0;
      r_period     <= DEB_W'(DEB_DEFAULT);
      r_irq        <= 1'b0;
    end else begin
      r_ready      <= w_hit;
      if (w_hit) r_rdata <= w_rdata_c;
      r_press      <= (r_press & ~w_press_clr) | w_press_set;
      r_release    <= (r_release & ~w_release_clr) | w_release_set;
      r_en_press   <= w_en_press_nxt;
      r_en_release <= w_en_release_nxt;
      r_period     <= w_period_nxt;
      r_irq        <= |{(r_press & r_en_press), (r_release & r_en_release)};
    end
  end

endmodule
